// File: rtl/lane_collect_if.sv
// Frame-in / beat-out bus for lane_collect.
// The slave side is the collector; the master side is its environment.
interface lane_collect_if #(
   parameter int WD = 4
);
   logic          IN_VALID;
   logic [WD-1:0] IN0;
   logic [WD-1:0] IN1;
   logic [WD-1:0] IN2;
   logic [WD-1:0] IN3;
   logic [WD-1:0] IN4;
   logic          IN_READY;
   logic          OUT_VALID;
   logic          OUT_READY;
   logic [WD-1:0] OUT_DATA;
   logic [2:0]    OUT_LANE;
   logic          OUT_LAST;
   logic [WD-1:0] OUT_CHK;
   logic [7:0]    FRAME_CNT;

   modport master (
      output IN_VALID, IN0, IN1, IN2, IN3, IN4, OUT_READY,
      input  IN_READY, OUT_VALID, OUT_DATA, OUT_LANE,
      input  OUT_LAST, OUT_CHK, FRAME_CNT
   );

   modport slave (
      input  IN_VALID, IN0, IN1, IN2, IN3, IN4, OUT_READY,
      output IN_READY, OUT_VALID, OUT_DATA, OUT_LANE,
      output OUT_LAST, OUT_CHK, FRAME_CNT
   );
endinterface

// File: rtl/lane_collect.sv
// Ping-pong frame buffer: takes 5 lanes in one cycle and
// replays them one lane per beat, with a per-frame XOR checksum.
module lane_collect #(
   parameter int WD = 4
) (
   input logic          CLK,
   input logic          RST_X,
   lane_collect_if.slave bus
);
   localparam int NLANE = 5;

   logic [WD-1:0] mem_q [2][NLANE];
   logic [WD-1:0] mem_d [2][NLANE];
   logic [WD-1:0] chk_q [2];
   logic [WD-1:0] chk_d [2];
   logic          wp_q, wp_d;
   logic          rp_q, rp_d;
   logic [2:0]    lp_q, lp_d;
   logic [1:0]    occ_q, occ_d;
   logic [7:0]    fcnt_q, fcnt_d;

   logic          acc;
   logic          beat;
   logic          last_xfer;
   logic          out_v;
   logic [WD-1:0] lane_word;

   assign bus.IN_READY  = (occ_q != 2'd2);
   assign out_v         = (occ_q != 2'd0);
   assign bus.OUT_VALID = out_v;
   assign acc           = bus.IN_VALID & bus.IN_READY;
   assign beat          = out_v & bus.OUT_READY;
   assign last_xfer     = beat & (lp_q == 3'd4);

   always_comb begin
      lane_word = '0;
      case (lp_q)
         3'd0:    lane_word = mem_q[rp_q][0];
         3'd1:    lane_word = mem_q[rp_q][1];
         3'd2:    lane_word = mem_q[rp_q][2];
         3'd3:    lane_word = mem_q[rp_q][3];
         3'd4:    lane_word = mem_q[rp_q][4];
         default: lane_word = '0;
      endcase
   end

   // Idle bus is forced to zero rather than showing stale slot data
   assign bus.OUT_DATA  = out_v ? lane_word : '0;
   assign bus.OUT_LANE  = out_v ? lp_q : 3'd0;
   assign bus.OUT_LAST  = out_v & (lp_q == 3'd4);
   assign bus.OUT_CHK   = out_v ? chk_q[rp_q] : '0;
   assign bus.FRAME_CNT = fcnt_q;

   always_comb begin
      mem_d  = mem_q;
      chk_d  = chk_q;
      wp_d   = wp_q;
      rp_d   = rp_q;
      lp_d   = lp_q;
      fcnt_d = fcnt_q;
      occ_d  = occ_q;
      if (acc) begin
         mem_d[wp_q][0] = bus.IN0;
         mem_d[wp_q][1] = bus.IN1;
         mem_d[wp_q][2] = bus.IN2;
         mem_d[wp_q][3] = bus.IN3;
         mem_d[wp_q][4] = bus.IN4;
         chk_d[wp_q]    = bus.IN0 ^ bus.IN1 ^ bus.IN2
                        ^ bus.IN3 ^ bus.IN4;
         wp_d           = ~wp_q;
      end
      if (beat) begin
         if (lp_q == 3'd4) begin
            lp_d   = 3'd0;
            rp_d   = ~rp_q;
            fcnt_d = fcnt_q + 8'd1;
         end else begin
            lp_d   = lp_q + 3'd1;
         end
      end
      // Capture on the final beat leaves occupancy unchanged
      if (acc && !last_xfer) begin
         occ_d = occ_q + 2'd1;
      end else if (!acc && last_xfer) begin
         occ_d = occ_q - 2'd1;
      end
   end

   always_ff @(posedge CLK or negedge RST_X) begin
      if (!RST_X) begin
         mem_q  <= '{default: '{default: '0}};
         chk_q  <= '{default: '0};
         wp_q   <= 1'b0;
         rp_q   <= 1'b0;
         lp_q   <= 3'd0;
         occ_q  <= 2'd0;
         fcnt_q <= 8'd0;
      end else begin
         mem_q  <= mem_d;
         chk_q  <= chk_d;
         wp_q   <= wp_d;
         rp_q   <= rp_d;
         lp_q   <= lp_d;
         occ_q  <= occ_d;
         fcnt_q <= fcnt_d;
      end
   end
endmodule

// File: tb/tb_lane_collect.sv
// Directed bench for lane_collect: streaming, back-pressure,
// overlap of capture with final beat, async reset and counter wrap.
module tb_lane_collect;
   logic CLK;
   logic RST_X;
   int   checks;
   int   errors;
   int   lasts;
   int   accepted;
   int   cyc;

   lane_collect_if #(.WD(4)) bus ();

   lane_collect #(.WD(4)) dut (
      .CLK   (CLK),
      .RST_X (RST_X),
      .bus   (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic frame(input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] c, input logic [3:0] d,
                        input logic [3:0] e);
      bus.IN_VALID = 1'b1;
      bus.IN0 = a;
      bus.IN1 = b;
      bus.IN2 = c;
      bus.IN3 = d;
      bus.IN4 = e;
   endtask

   task automatic beat(input string tag, input logic [3:0] data,
                       input logic [2:0] lane);
      chk({tag, "_valid"}, 32'(bus.OUT_VALID), 32'd1);
      chk({tag, "_data"}, 32'(bus.OUT_DATA), 32'(data));
      chk({tag, "_lane"}, 32'(bus.OUT_LANE), 32'(lane));
      chk({tag, "_last"}, 32'(bus.OUT_LAST), 32'(lane == 3'd4));
   endtask

   task automatic idle_out(input string tag);
      chk({tag, "_ready"}, 32'(bus.IN_READY), 32'd1);
      chk({tag, "_valid"}, 32'(bus.OUT_VALID), 32'd0);
      chk({tag, "_data"}, 32'(bus.OUT_DATA), 32'd0);
      chk({tag, "_lane"}, 32'(bus.OUT_LANE), 32'd0);
      chk({tag, "_last"}, 32'(bus.OUT_LAST), 32'd0);
      chk({tag, "_chk"}, 32'(bus.OUT_CHK), 32'd0);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      RST_X = 1'b0;
      bus.IN_VALID = 1'b0;
      bus.IN0 = '0;
      bus.IN1 = '0;
      bus.IN2 = '0;
      bus.IN3 = '0;
      bus.IN4 = '0;
      bus.OUT_READY = 1'b0;
      #1;
      idle_out("rst");
      chk("rst_fcnt", 32'(bus.FRAME_CNT), 32'd0);
      step();
      step();
      RST_X = 1'b1;

      // single frame 1..5 with free-running sink
      bus.OUT_READY = 1'b1;
      frame(4'h1, 4'h2, 4'h3, 4'h4, 4'h5);
      step();
      bus.IN_VALID = 1'b0;
      for (int i = 0; i < 5; i++) begin
         beat("single", 4'(i + 1), 3'(i));
         if (i == 4) chk("single_chk", 32'(bus.OUT_CHK), 32'h1);
         step();
      end
      chk("single_fcnt", 32'(bus.FRAME_CNT), 32'd1);
      chk("single_done", 32'(bus.OUT_VALID), 32'd0);

      // back-pressure fill: third frame must be held off
      bus.OUT_READY = 1'b0;
      frame(4'h6, 4'h7, 4'h8, 4'h9, 4'hA);
      step();
      chk("bp1_ready", 32'(bus.IN_READY), 32'd1);
      beat("bp1", 4'h6, 3'd0);
      frame(4'hB, 4'hC, 4'hD, 4'hE, 4'hF);
      step();
      chk("bp2_ready", 32'(bus.IN_READY), 32'd0);
      beat("bp2", 4'h6, 3'd0);
      frame(4'h1, 4'h1, 4'h1, 4'h1, 4'h1);
      step();
      chk("bp3_ready", 32'(bus.IN_READY), 32'd0);
      beat("bp3", 4'h6, 3'd0);

      // advance to lane 2, then stall three cycles
      bus.OUT_READY = 1'b1;
      step();
      beat("adv1", 4'h7, 3'd1);
      step();
      beat("adv2", 4'h8, 3'd2);
      bus.OUT_READY = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         beat("stall", 4'h8, 3'd2);
      end
      bus.OUT_READY = 1'b1;
      step();
      beat("resume", 4'h9, 3'd3);
      step();
      beat("fa_l4", 4'hA, 3'd4);
      chk("fa_chk", 32'(bus.OUT_CHK), 32'hA);
      chk("fa_l4_ready", 32'(bus.IN_READY), 32'd0);
      step();
      chk("held_ready", 32'(bus.IN_READY), 32'd1);
      beat("fb_l0", 4'hB, 3'd0);
      step();
      bus.IN_VALID = 1'b0;
      chk("fc_in_ready", 32'(bus.IN_READY), 32'd0);
      beat("fb_l1", 4'hC, 3'd1);
      step();
      step();
      step();
      beat("fb_l4", 4'hF, 3'd4);
      chk("fb_chk", 32'(bus.OUT_CHK), 32'hB);
      step();
      beat("fc_l0", 4'h1, 3'd0);
      chk("fc_fcnt", 32'(bus.FRAME_CNT), 32'd3);
      step();
      step();
      step();
      step();
      beat("fc_l4", 4'h1, 3'd4);
      chk("fc_chk", 32'(bus.OUT_CHK), 32'h1);

      // capture coincides with final beat at occupancy 1
      frame(4'h2, 4'h4, 4'h8, 4'h3, 4'h5);
      step();
      bus.IN_VALID = 1'b0;
      beat("ovl_l0", 4'h2, 3'd0);
      chk("ovl_ready", 32'(bus.IN_READY), 32'd1);
      chk("ovl_fcnt", 32'(bus.FRAME_CNT), 32'd4);
      step();
      step();
      step();
      beat("fd_l3", 4'h3, 3'd3);

      // fill second slot at lane 3, then reset asynchronously
      bus.OUT_READY = 1'b0;
      frame(4'h7, 4'h7, 4'h7, 4'h7, 4'h7);
      step();
      bus.IN_VALID = 1'b0;
      chk("pre_rst_ready", 32'(bus.IN_READY), 32'd0);
      #2;
      RST_X = 1'b0;
      #1;
      idle_out("arst");
      chk("arst_fcnt", 32'(bus.FRAME_CNT), 32'd0);
      step();
      step();
      RST_X = 1'b1;
      bus.OUT_READY = 1'b1;
      frame(4'hA, 4'hB, 4'hC, 4'hD, 4'hE);
      step();
      bus.IN_VALID = 1'b0;
      for (int i = 0; i < 5; i++) begin
         beat("post_rst", 4'(4'hA + i), 3'(i));
         if (i == 4) chk("post_rst_chk", 32'(bus.OUT_CHK), 32'hE);
         step();
      end
      chk("post_rst_done", 32'(bus.OUT_VALID), 32'd0);
      chk("post_rst_fcnt", 32'(bus.FRAME_CNT), 32'd1);

      // 256 all-F frames back to back: counter wraps to 0
      RST_X = 1'b0;
      step();
      RST_X = 1'b1;
      lasts = 0;
      accepted = 0;
      cyc = 0;
      frame(4'hF, 4'hF, 4'hF, 4'hF, 4'hF);
      while (lasts < 256 && cyc < 5000) begin
         if (bus.OUT_VALID && bus.OUT_LAST) begin
            chk("wrap_chk", 32'(bus.OUT_CHK), 32'hF);
            lasts++;
         end
         if (bus.IN_VALID && bus.IN_READY) accepted++;
         step();
         if (accepted == 256) bus.IN_VALID = 1'b0;
         cyc++;
      end
      chk("wrap_frames", 32'(lasts), 32'd256);
      chk("wrap_cycles", 32'(cyc), 32'd1281);
      chk("wrap_fcnt", 32'(bus.FRAME_CNT), 32'd0);
      chk("wrap_idle", 32'(bus.OUT_VALID), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
